multiplier_ctrl: RTL
====================

# multiplier_ctrl

Control FSM for the RV32M byte-sliced multiplier datapath. Accepts a multiply request (funct3, operands, destination tag) from the issue stage and sequences the datapath through load, four diagonal-product compute cycles and one pipeline-drain cycle. It also decodes signedness and upper/lower select, and signals completion with the destination tag. It sits directly upstream of `multiplier_DP` and drives every control input of that block.

## Interface
- Parameters: none.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  request valid; sampled only in IDLE or DONE.
- `funct3_i`  in  3  RV32M funct3; 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- `rd_i`  in  5  destination register tag, latched on accept.
- `kill_i`  in  1  pipeline flush; aborts the operation in flight.
- `busy_o`  out  1  high in LOAD, C0–C3 and DRAIN.
- `done_o`  out  1  one-cycle pulse; the datapath result is valid this cycle.
- `rd_o`  out  5  latched tag; valid while `done_o`=1.
- `illegal_o`  out  1  one-cycle pulse when the accepted funct3 has bit 2 set.
- `upper_o`, `signed_A_o`, `signed_B_o`  out  1 each  decoded operation controls.
- `reg_A_en_o`, `reg_B_en_o`, `mux_B_sel_o`, `rol_en_o`, `en_pipe_o`, `AC_en_o`  out  1 each  datapath strobes.
- `shift_amount_o`  out  2  product shift select.
- `ac_clr_o`  out  1  synchronous accumulator clear, wired to the datapath accumulator.

## Operation
- States: IDLE, LOAD, C0, C1, C2, C3, DRAIN, DONE. Reset enters IDLE; all outputs and `rd_o` reset to 0.
- Decode of `upper_o`/`signed_A_o`/`signed_B_o`:
  - 000 → 0/0/0
  - 001 → 1/1/1
  - 010 → 1/1/0
  - 011 → 1/0/0
- The decoded values are registered on accept and held until the next accept.
- IDLE: `start_i`=1 with `funct3_i[2]`=0 → LOAD, latching `rd_i`. With `funct3_i[2]`=1 → `illegal_o`=1 the next cycle and the FSM stays in IDLE.
- LOAD drives `reg_A_en_o`=1, `reg_B_en_o`=1, `mux_B_sel_o`=0, `rol_en_o`=0 and `ac_clr_o`=1.
- Ck (k=0..3) drives `en_pipe_o`=1 and `AC_en_o`=1.
- `shift_amount_o` in C0, C1, C2, C3 is 00, 01, 11, 10, in that order (Gray sequence matching B rotation by 0/1/2/3 bytes).
- C0–C2 also drive `reg_B_en_o`=1, `mux_B_sel_o`=1, `rol_en_o`=1 (rotate B left by 8). C3 drives all three to 0.
- DRAIN drives `en_pipe_o`=1 and `AC_en_o`=0, so the C3 product is accumulated and the pipeline AC enable clears.
- DONE drives `done_o`=1. `start_i` in DONE is accepted exactly as in IDLE, giving back-to-back operation. Otherwise DONE → IDLE.
- In IDLE and DONE, all strobes are 0 except as stated above.
- `start_i` in any busy state is ignored; there is no queuing.
- `kill_i`=1 in any busy state → IDLE next cycle, with no `done_o`. `kill_i` has priority over `start_i` in DONE; `done_o` still pulses that cycle.
- Reset asserted mid-operation → IDLE immediately with all outputs 0. The datapath is reset by the same net, inverted.

## Timing
- Accept edge = edge 0. LOAD occupies cycle 1, C0–C3 cycles 2–5, DRAIN cycle 6, DONE cycle 7.
- Latency is 7 cycles from accept to `done_o`. Issue interval is 7 cycles back-to-back.
- Accumulator cleared at the end of LOAD. It updates at the ends of cycles 3–6, so the final value is present during DONE.
- Strobes are registered (Moore) outputs; they take no combinational path from `start_i`.
- `illegal_o` follows the rejecting edge by one cycle and lasts one cycle.

## Test plan
- MUL 0x00000007 × 0xFFFFFFFD, rd=5 → `done_o` 7 cycles after accept, result 0xFFFFFFEB, `rd_o`=5.
- MULH 0x80000000 × 0x80000000 → result 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- Strobe trace for any operation: `shift_amount_o` = 00, 01, 11, 10 on cycles 2–5; `rol_en_o` high on cycles 2–4 only; `ac_clr_o` high on cycle 1 only.
- Back-to-back: second `start_i` held during DONE → second LOAD on the next cycle, second `done_o` exactly 7 cycles after the first, correct independent results.
- `kill_i` in C2 → IDLE the next cycle, no `done_o`. A fresh MUL 3×4 afterwards → result 12.
- funct3=100 → `illegal_o` one cycle, `busy_o` stays 0. `rst_ni` low during C1 → all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/multiplier_ctrl.sv
// Control sequencer for the byte-sliced RV32M multiplier datapath: accepts a request,
// walks LOAD -> C0..C3 -> DRAIN -> DONE and drives every datapath strobe from the state.
module multiplier_ctrl (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [2:0] funct3_i,
    input  logic [4:0] rd_i,
    input  logic       kill_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [4:0] rd_o,
    output logic       illegal_o,
    output logic       upper_o,
    output logic       signed_A_o,
    output logic       signed_B_o,
    output logic       reg_A_en_o,
    output logic       reg_B_en_o,
    output logic       mux_B_sel_o,
    output logic       rol_en_o,
    output logic       en_pipe_o,
    output logic       AC_en_o,
    output logic [1:0] shift_amount_o,
    output logic       ac_clr_o,
    output logic [2:0] state_o
);

    // Handshake: a request is taken when start_i=1 while the FSM is in IDLE, or in DONE
    // without kill_i; there is no ready signal and requests seen while busy are dropped.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_C0    = 3'd2,
        S_C1    = 3'd3,
        S_C2    = 3'd4,
        S_C3    = 3'd5,
        S_DRAIN = 3'd6,
        S_DONE  = 3'd7
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] rd_q;
    logic       upper_q, signed_a_q, signed_b_q, illegal_q;
    logic       can_accept, accept, reject;

    assign can_accept = (state_q == S_IDLE) || ((state_q == S_DONE) && !kill_i);
    assign accept     = can_accept && start_i && !funct3_i[2];
    assign reject     = can_accept && start_i && funct3_i[2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            rd_q       <= 5'd0;
            upper_q    <= 1'b0;
            signed_a_q <= 1'b0;
            signed_b_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= reject;
            if (accept) begin
                rd_q       <= rd_i;
                // 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
                upper_q    <= funct3_i[1] | funct3_i[0];
                signed_a_q <= funct3_i[1] ^ funct3_i[0];
                signed_b_q <= funct3_i[0] & ~funct3_i[1];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        reg_A_en_o     = 1'b0;
        reg_B_en_o     = 1'b0;
        mux_B_sel_o    = 1'b0;
        rol_en_o       = 1'b0;
        en_pipe_o      = 1'b0;
        AC_en_o        = 1'b0;
        ac_clr_o       = 1'b0;
        shift_amount_o = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_LOAD;
            end
            S_LOAD: begin
                busy_o     = 1'b1;
                reg_A_en_o = 1'b1;
                reg_B_en_o = 1'b1;
                ac_clr_o   = 1'b1;
                state_d    = S_C0;
            end
            S_C0: begin
                busy_o      = 1'b1;
                en_pipe_o   = 1'b1;
                AC_en_o     = 1'b1;
                reg_B_en_o  = 1'b1;
                mux_B_sel_o = 1'b1;
                rol_en_o    = 1'b1;
                state_d     = S_C1;
            end
            S_C1: begin
                busy_o         = 1'b1;
                en_pipe_o      = 1'b1;
                AC_en_o        = 1'b1;
                reg_B_en_o     = 1'b1;
                mux_B_sel_o    = 1'b1;
                rol_en_o       = 1'b1;
                shift_amount_o = 2'b01;
                state_d        = S_C2;
            end
            S_C2: begin
                busy_o         = 1'b1;
                en_pipe_o      = 1'b1;
                AC_en_o        = 1'b1;
                reg_B_en_o     = 1'b1;
                mux_B_sel_o    = 1'b1;
                rol_en_o       = 1'b1;
                shift_amount_o = 2'b11;
                state_d        = S_C3;
            end
            S_C3: begin
                // B has been rotated by three bytes; hold it for the last diagonal.
                busy_o         = 1'b1;
                en_pipe_o      = 1'b1;
                AC_en_o        = 1'b1;
                shift_amount_o = 2'b10;
                state_d        = S_DRAIN;
            end
            S_DRAIN: begin
                busy_o    = 1'b1;
                en_pipe_o = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = accept ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (kill_i && busy_o) state_d = S_IDLE;
    end

    assign rd_o       = rd_q;
    assign illegal_o  = illegal_q;
    assign upper_o    = upper_q;
    assign signed_A_o = signed_a_q;
    assign signed_B_o = signed_b_q;
    assign state_o    = state_q;

endmodule
